// File: rtl/exec_pkg.sv
// ==========================================================================
// exec_pkg: shared FU indices, default widths and op tag type for execute.
// Revision: 1.0
// ==========================================================================
`default_nettype none

package exec_pkg;

    localparam int FU_SIMPLE  = 0;
    localparam int FU_FP      = 1;
    localparam int FU_COMPLEX = 2;
    localparam int FU_PRED    = 3;
    localparam int FU_MEM     = 4;

    localparam int EXEC_NUM_FU = 5;
    localparam int EXEC_ROB_W  = 4;
    localparam int EXEC_DEST_W = 3;
    localparam int EXEC_LAT_W  = 5;
    localparam int EXEC_CTRL_W = 6;

    typedef struct packed {
        logic [EXEC_ROB_W-1:0]  rob;
        logic [EXEC_DEST_W-1:0] dest;
        logic [EXEC_CTRL_W-1:0] ctrl;
    } exec_tag_t;

endpackage

`default_nettype wire

// File: rtl/exec_fu_slot.sv
// ==========================================================================
// exec_fu_slot: per-FU latency countdown and result holding slot.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module exec_fu_slot
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = EXEC_CTRL_W,
    parameter int ROB_W      = EXEC_ROB_W,
    parameter int DEST_W     = EXEC_DEST_W,
    parameter int LAT_W      = EXEC_LAT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  accept_i,
    input  logic [LAT_W-1:0]      latency_i,
    input  logic [ROB_W-1:0]      rob_i,
    input  logic [DEST_W-1:0]     dest_i,
    input  logic [CTRL_WIDTH-1:0] ctrl_i,
    input  logic [DATA_WIDTH-1:0] result_i,
    input  logic                  drain_i,
    output logic                  slot_valid_o,
    output logic                  fu_free_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [ROB_W-1:0]      rob_o,
    output logic [DEST_W-1:0]     dest_o,
    output logic [CTRL_WIDTH-1:0] ctrl_o
);

    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic [LAT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ROB_W-1:0]      rob_q, rob_d;
    logic [DEST_W-1:0]     dest_q, dest_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;

    always_comb begin
        busy_d  = busy_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rob_d   = rob_q;
        dest_d  = dest_q;
        ctrl_d  = ctrl_q;
        if (flush_i) begin
            busy_d  = 1'b0;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else if (accept_i) begin
            // Accept implies the slot is empty or draining this edge.
            rob_d  = rob_i;
            dest_d = dest_i;
            ctrl_d = ctrl_i;
            if (latency_i == '0) begin
                data_d  = result_i;
                valid_d = 1'b1;
            end else begin
                busy_d  = 1'b1;
                cnt_d   = latency_i;
                valid_d = 1'b0;
            end
        end else if (busy_q) begin
            cnt_d = cnt_q - LAT_W'(1);
            if (cnt_q == LAT_W'(1)) begin
                data_d  = result_i;
                valid_d = 1'b1;
                busy_d  = 1'b0;
            end
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            rob_q   <= '0;
            dest_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rob_q   <= rob_d;
            dest_q  <= dest_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign slot_valid_o = valid_q;
    assign fu_free_o    = !busy_q && (!valid_q || drain_i);
    assign data_o       = data_q;
    assign rob_o        = rob_q;
    assign dest_o       = dest_q;
    assign ctrl_o       = ctrl_q;

endmodule

`default_nettype wire

// File: rtl/exec_completion_arb.sv
// ==========================================================================
// exec_completion_arb: per-FU completion slots arbitrated onto one WB bus.
// EXEC_RR_ARB_EN selects round-robin instead of highest-index priority.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module exec_completion_arb
    import exec_pkg::*;
#(
    parameter int NUM_FU     = EXEC_NUM_FU,
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = EXEC_CTRL_W,
    parameter int ROB_W      = EXEC_ROB_W,
    parameter int DEST_W     = EXEC_DEST_W,
    parameter int LAT_W      = EXEC_LAT_W,
    parameter int FU_IDX_W   = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         issue_valid,
    input  logic [FU_IDX_W-1:0]          issue_fu,
    input  logic [LAT_W-1:0]             issue_latency,
    input  logic [ROB_W-1:0]             issue_rob_entry,
    input  logic [DEST_W-1:0]            issue_dest_reg,
    input  logic [CTRL_WIDTH-1:0]        issue_ctrl,
    output logic                         issue_ready,
    input  logic [NUM_FU*DATA_WIDTH-1:0] fu_result,
    output logic [NUM_FU-1:0]            fu_free,
    output logic                         wb_valid,
    input  logic                         wb_ready,
    output logic [FU_IDX_W-1:0]          wb_fu,
    output logic [DATA_WIDTH-1:0]        wb_data,
    output logic [ROB_W-1:0]             wb_rob_entry,
    output logic [DEST_W-1:0]            wb_dest_reg,
    output logic [CTRL_WIDTH-1:0]        wb_ctrl
);

    logic [NUM_FU-1:0]     slot_valid;
    logic [NUM_FU-1:0]     accept;
    logic [NUM_FU-1:0]     drain;
    logic [DATA_WIDTH-1:0] slot_data [NUM_FU];
    logic [ROB_W-1:0]      slot_rob  [NUM_FU];
    logic [DEST_W-1:0]     slot_dest [NUM_FU];
    logic [CTRL_WIDTH-1:0] slot_ctrl [NUM_FU];

    logic                  lock_q, lock_d;
    logic [FU_IDX_W-1:0]   lock_fu_q, lock_fu_d;
    logic [FU_IDX_W-1:0]   arb_fu;
    logic [FU_IDX_W-1:0]   grant;
    logic                  xfer;

    always_comb begin
        issue_ready = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (issue_fu == FU_IDX_W'(i)) issue_ready = fu_free[i] && !flush;
        end
    end

    generate
        for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
            assign accept[g] = issue_valid && issue_ready && (issue_fu == FU_IDX_W'(g));
            assign drain[g]  = xfer && (grant == FU_IDX_W'(g));

            exec_fu_slot #(
                .DATA_WIDTH (DATA_WIDTH),
                .CTRL_WIDTH (CTRL_WIDTH),
                .ROB_W      (ROB_W),
                .DEST_W     (DEST_W),
                .LAT_W      (LAT_W)
            ) u_slot (
                .clk          (clk),
                .reset        (reset),
                .flush_i      (flush),
                .accept_i     (accept[g]),
                .latency_i    (issue_latency),
                .rob_i        (issue_rob_entry),
                .dest_i       (issue_dest_reg),
                .ctrl_i       (issue_ctrl),
                .result_i     (fu_result[g*DATA_WIDTH +: DATA_WIDTH]),
                .drain_i      (drain[g]),
                .slot_valid_o (slot_valid[g]),
                .fu_free_o    (fu_free[g]),
                .data_o       (slot_data[g]),
                .rob_o        (slot_rob[g]),
                .dest_o       (slot_dest[g]),
                .ctrl_o       (slot_ctrl[g])
            );
        end
    endgenerate

`ifdef EXEC_RR_ARB_EN
    logic [FU_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic                found_hi;
    logic [FU_IDX_W-1:0] hi_fu, lo_fu;

    // Lowest valid index above the pointer, else lowest valid index overall.
    always_comb begin
        found_hi = 1'b0;
        hi_fu    = '0;
        lo_fu    = '0;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (slot_valid[i]) begin
                if (FU_IDX_W'(i) > rr_ptr_q) begin
                    found_hi = 1'b1;
                    hi_fu    = FU_IDX_W'(i);
                end else begin
                    lo_fu = FU_IDX_W'(i);
                end
            end
        end
        arb_fu = found_hi ? hi_fu : lo_fu;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (flush)     rr_ptr_d = FU_IDX_W'(NUM_FU - 1);
        else if (xfer) rr_ptr_d = grant;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_ptr_q <= FU_IDX_W'(NUM_FU - 1);
        else       rr_ptr_q <= rr_ptr_d;
    end
`else
    always_comb begin
        arb_fu = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (slot_valid[i]) arb_fu = FU_IDX_W'(i);
        end
    end
`endif

    assign grant    = lock_q ? lock_fu_q : arb_fu;
    assign wb_valid = (|slot_valid) && !flush;
    assign xfer     = wb_valid && wb_ready;

    always_comb begin
        wb_fu        = '0;
        wb_data      = '0;
        wb_rob_entry = '0;
        wb_dest_reg  = '0;
        wb_ctrl      = '0;
        if (wb_valid) begin
            wb_fu = grant;
            for (int i = 0; i < NUM_FU; i++) begin
                if (grant == FU_IDX_W'(i)) begin
                    wb_data      = slot_data[i];
                    wb_rob_entry = slot_rob[i];
                    wb_dest_reg  = slot_dest[i];
                    wb_ctrl      = slot_ctrl[i];
                end
            end
        end
    end

    // A stalled grant is frozen so the payload cannot change under the consumer.
    always_comb begin
        lock_d    = lock_q;
        lock_fu_d = lock_fu_q;
        if (flush) begin
            lock_d = 1'b0;
        end else if (wb_valid && !wb_ready) begin
            lock_d    = 1'b1;
            lock_fu_d = grant;
        end else if (xfer) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q    <= 1'b0;
            lock_fu_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_fu_q <= lock_fu_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_exec_completion_arb.sv
// ==========================================================================
// tb_exec_completion_arb: directed vector table plus reset/flush sequences.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_exec_completion_arb;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        issue_valid;
    logic [2:0]  issue_fu;
    logic [4:0]  issue_latency;
    logic [3:0]  issue_rob_entry;
    logic [2:0]  issue_dest_reg;
    logic [5:0]  issue_ctrl;
    logic        issue_ready;
    logic [159:0] fu_result;
    logic [4:0]  fu_free;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_fu;
    logic [31:0] wb_data;
    logic [3:0]  wb_rob_entry;
    logic [2:0]  wb_dest_reg;
    logic [5:0]  wb_ctrl;

    int vectors = 0;
    int miscompares = 0;

    exec_completion_arb dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .issue_valid     (issue_valid),
        .issue_fu        (issue_fu),
        .issue_latency   (issue_latency),
        .issue_rob_entry (issue_rob_entry),
        .issue_dest_reg  (issue_dest_reg),
        .issue_ctrl      (issue_ctrl),
        .issue_ready     (issue_ready),
        .fu_result       (fu_result),
        .fu_free         (fu_free),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .wb_fu           (wb_fu),
        .wb_data         (wb_data),
        .wb_rob_entry    (wb_rob_entry),
        .wb_dest_reg     (wb_dest_reg),
        .wb_ctrl         (wb_ctrl)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       iv;
        logic [2:0] fu;
        logic [4:0] lat;
        logic [3:0] rob;
        logic       wr;
        logic       ev;
        logic [2:0] efu;
        logic [31:0] edata;
        logic [3:0] erob;
        logic [4:0] efree;
        logic       eir;
    } vec_t;

    vec_t vt[40];
    int   nv = 0;

    task automatic add(input string nm, input logic iv, input logic [2:0] fu,
                       input logic [4:0] lat, input logic [3:0] rob, input logic wr,
                       input logic ev, input logic [2:0] efu, input logic [31:0] edata,
                       input logic [3:0] erob, input logic [4:0] efree, input logic eir);
        vt[nv].name = nm;   vt[nv].iv = iv;     vt[nv].fu = fu;
        vt[nv].lat = lat;   vt[nv].rob = rob;   vt[nv].wr = wr;
        vt[nv].ev = ev;     vt[nv].efu = efu;   vt[nv].edata = edata;
        vt[nv].erob = erob; vt[nv].efree = efree; vt[nv].eir = eir;
        nv++;
    endtask

    // Dest and ctrl are derived from the ROB tag so every tag field is checkable.
    task automatic drive(input logic iv, input logic [2:0] fu, input logic [4:0] lat,
                         input logic [3:0] rob, input logic wr, input logic fl);
        issue_valid     = iv;
        issue_fu        = fu;
        issue_latency   = lat;
        issue_rob_entry = rob;
        issue_dest_reg  = rob[2:0] ^ 3'b101;
        issue_ctrl      = {rob, 2'b11};
        wb_ready        = wr;
        flush           = fl;
    endtask

    task automatic check(input string nm, input logic ev, input logic [2:0] efu,
                         input logic [31:0] edata, input logic [3:0] erob,
                         input logic [4:0] efree, input logic eir);
        logic [2:0] edest;
        logic [5:0] ectrl;
        logic       bad;
        edest = ev ? (erob[2:0] ^ 3'b101) : 3'b000;
        ectrl = ev ? {erob, 2'b11} : 6'h00;
        vectors++;
        bad = (wb_valid !== ev) || (ev && wb_fu !== efu) || (wb_data !== edata) ||
              (wb_rob_entry !== erob) || (wb_dest_reg !== edest) || (wb_ctrl !== ectrl) ||
              (fu_free !== efree) || (issue_ready !== eir);
        if (bad) begin
            miscompares++;
            $display("FAIL %s: got v=%0b fu=%0d data=%h rob=%0d dest=%0d ctrl=%h free=%b ir=%0b; expected v=%0b fu=%0d data=%h rob=%0d dest=%0d ctrl=%h free=%b ir=%0b",
                     nm, wb_valid, wb_fu, wb_data, wb_rob_entry, wb_dest_reg, wb_ctrl, fu_free, issue_ready,
                     ev, efu, edata, erob, edest, ectrl, efree, eir);
        end
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            drive(vt[i].iv, vt[i].fu, vt[i].lat, vt[i].rob, vt[i].wr, 1'b0);
            #1;
            check(vt[i].name, vt[i].ev, vt[i].efu, vt[i].edata, vt[i].erob, vt[i].efree, vt[i].eir);
        end
    endtask

    task automatic expect_quiet(input string nm, input int cycles);
        logic saw;
        saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            drive(1'b0, 3'd0, 5'd0, 4'd0, 1'b1, 1'b0);
            #1;
            if (wb_valid) saw = 1'b1;
        end
        vectors++;
        if (saw) begin
            miscompares++;
            $display("FAIL %s: got a writeback, expected none", nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int part1_end;
        int part2_end;

        fu_result = {32'h0000_4444, 32'h0000_3333, 32'h0000_1234, 32'h0000_1111, 32'h0000_A0A0};
        reset = 1'b1;
        drive(1'b0, 3'd0, 5'd0, 4'd0, 1'b1, 1'b0);

        add("reset_idle",  0, 0, 0, 0, 1,  0, 0, 32'h0,    0, 5'b11111, 1);
        add("lat_issue",   1, 2, 3, 5, 1,  0, 0, 32'h0,    0, 5'b11111, 1);
        add("lat_cnt3",    0, 0, 0, 0, 1,  0, 0, 32'h0,    0, 5'b11011, 1);
        add("lat_cnt2",    0, 0, 0, 0, 1,  0, 0, 32'h0,    0, 5'b11011, 1);
        add("lat_cnt1",    0, 0, 0, 0, 1,  0, 0, 32'h0,    0, 5'b11011, 1);
        add("lat_stall",   0, 0, 0, 0, 0,  1, 2, 32'h1234, 5, 5'b11011, 1);
        add("lat_xfer",    0, 0, 0, 0, 1,  1, 2, 32'h1234, 5, 5'b11111, 1);
        add("illegal_fu",  0, 5, 0, 0, 1,  0, 0, 32'h0,    0, 5'b11111, 0);
        add("lock_fu0",    1, 0, 0, 7, 0,  0, 0, 32'h0,    0, 5'b11111, 1);
        add("lock_fu3",    1, 3, 0, 9, 0,  1, 0, 32'hA0A0, 7, 5'b11110, 1);
        add("lock_hold",   0, 0, 0, 0, 0,  1, 0, 32'hA0A0, 7, 5'b10110, 0);
        add("lock_xfer",   0, 0, 0, 0, 1,  1, 0, 32'hA0A0, 7, 5'b10111, 1);
        add("lock_next",   0, 0, 0, 0, 1,  1, 3, 32'h3333, 9, 5'b11111, 1);
        add("lock_idle",   0, 0, 0, 0, 1,  0, 0, 32'h0,    0, 5'b11111, 1);
        part1_end = nv;

        add("prio_iss1",   1, 1, 2, 1, 1,  0, 0, 32'h0,    0, 5'b11111, 1);
        add("prio_iss3",   1, 3, 1, 3, 1,  0, 0, 32'h0,    0, 5'b11101, 1);
        add("prio_iss4",   1, 4, 0, 4, 1,  0, 0, 32'h0,    0, 5'b10101, 1);
`ifdef EXEC_RR_ARB_EN
        add("prio_wb_a",   0, 0, 0, 0, 1,  1, 1, 32'h1111, 1, 5'b00111, 1);
        add("prio_wb_b",   0, 0, 0, 0, 1,  1, 3, 32'h3333, 3, 5'b01111, 1);
        add("prio_wb_c",   0, 0, 0, 0, 1,  1, 4, 32'h4444, 4, 5'b11111, 1);
`else
        add("prio_wb_a",   0, 0, 0, 0, 1,  1, 4, 32'h4444, 4, 5'b10101, 1);
        add("prio_wb_b",   0, 0, 0, 0, 1,  1, 3, 32'h3333, 3, 5'b11101, 1);
        add("prio_wb_c",   0, 0, 0, 0, 1,  1, 1, 32'h1111, 1, 5'b11111, 1);
`endif
        add("prio_idle",   0, 0, 0, 0, 1,  0, 0, 32'h0,    0, 5'b11111, 1);
        add("reiss_first", 1, 0, 0, 10, 0, 0, 0, 32'h0,    0, 5'b11111, 1);
        add("reiss_drain", 1, 0, 0, 11, 1, 1, 0, 32'hA0A0, 10, 5'b11111, 1);
        add("reiss_wb2",   0, 0, 0, 0, 1,  1, 0, 32'hA0A0, 11, 5'b11111, 1);
        add("reiss_idle",  0, 0, 0, 0, 1,  0, 0, 32'h0,    0, 5'b11111, 1);
        part2_end = nv;

        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_range(0, part1_end);

        // Reset in the middle of a latency-4 op on FU1.
        @(negedge clk); drive(1'b1, 3'd1, 5'd4, 4'd3, 1'b1, 1'b0); #1;
        check("rst_issue", 0, 0, 32'h0, 0, 5'b11111, 1);
        @(negedge clk); drive(1'b0, 3'd0, 5'd0, 4'd0, 1'b1, 1'b0); #1;
        check("rst_busy_a", 0, 0, 32'h0, 0, 5'b11101, 1);
        @(negedge clk); #1;
        check("rst_busy_b", 0, 0, 32'h0, 0, 5'b11101, 1);
        @(negedge clk); reset = 1'b1; #1;
        check("rst_async", 0, 0, 32'h0, 0, 5'b11111, 1);
        @(negedge clk); reset = 1'b0;
        expect_quiet("rst_no_wb", 8);

        run_range(part1_end, part2_end);

        // Flush with two ops in flight, one valid slot and a same-cycle issue.
        @(negedge clk); drive(1'b1, 3'd1, 5'd3, 4'd1, 1'b1, 1'b0); #1;
        check("fl_iss1", 0, 0, 32'h0, 0, 5'b11111, 1);
        @(negedge clk); drive(1'b1, 3'd2, 5'd5, 4'd2, 1'b1, 1'b0); #1;
        check("fl_iss2", 0, 0, 32'h0, 0, 5'b11101, 1);
        @(negedge clk); drive(1'b1, 3'd4, 5'd0, 4'd4, 1'b0, 1'b0); #1;
        check("fl_iss4", 0, 0, 32'h0, 0, 5'b11001, 1);
        @(negedge clk); drive(1'b1, 3'd0, 5'd0, 4'd6, 1'b1, 1'b1); #1;
        check("fl_cycle", 0, 0, 32'h0, 0, 5'b01001, 0);
        @(negedge clk); drive(1'b0, 3'd0, 5'd0, 4'd0, 1'b1, 1'b0); #1;
        check("fl_after", 0, 0, 32'h0, 0, 5'b11111, 1);
        expect_quiet("fl_no_wb", 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
